tone_nco: RTL and testbench
===========================

// Module: tone_nco
// PURPOSE
//   Numerically controlled oscillator that produces the sample code for the PWM DAC stage.
//   Holds a phase accumulator that advances by a frequency control word (FCW).
//   The accumulator advances once per DAC window, on the DAC's next_sample pulse.
//   Maps the phase to a square, sawtooth or triangle code that the DAC consumes on its next window.
//   Sits directly upstream of the DAC: code -> dac.code; dac.next_sample -> next_sample.
// PARAMETERS
//   CODE_WIDTH   10        width of code output; must match the DAC's code width
//   PHASE_WIDTH  24        phase accumulator / FCW width; must be >= CODE_WIDTH+2
//   FCW_DEFAULT  24'd3436  FCW loaded on reset
//   FCW_STEP     24'd64    amount added/subtracted per fcw_up/fcw_down pulse
// PORTS
//   clk          in   1            system clock, single clock domain
//   rst          in   1            synchronous, active-high reset
//   next_sample  in   1            1-cycle pulse from DAC: last cycle of current PWM window
//   enable       in   1            1 = oscillate; 0 = hold phase, output silence
//   wave_sel     in   2            0 square, 1 sawtooth, 2 triangle, 3 silence
//   fcw_up       in   1            1-cycle pulse: raise FCW by FCW_STEP
//   fcw_down     in   1            1-cycle pulse: lower FCW by FCW_STEP
//   code         out  CODE_WIDTH   registered sample code to DAC
//   fcw          out  PHASE_WIDTH  current FCW (registered, for debug/LEDs)
// BEHAVIOUR
//   Reset (rst=1 at posedge, overrides all other inputs)
//     - phase <= 0, fcw <= FCW_DEFAULT, code <= 0.
//     - Mid-operation reset takes effect on that edge; a next_sample pulse in the same cycle is ignored.
//   Phase update (edge with next_sample=1 and enable=1)
//     - phase <= (phase + fcw) mod 2^PHASE_WIDTH; wrap-around is silent.
//     - The FCW used is the value registered before this edge.
//     - An fcw_up/fcw_down pulse in the same cycle affects only later updates.
//     - next_sample=0 or enable=0: phase holds.
//   Code update (same edges as the phase update, plus next_sample=1 with enable=0)
//     - code <= f(phase_next); the DAC therefore sees the new code from the first cycle of the next window.
//     - Latency: 1 cycle from the next_sample pulse; code is stable for the whole window.
//     - Definitions, with CW=CODE_WIDTH and PW=PHASE_WIDTH:
//         s = phase_next[PW-1 -: CW]
//         t = phase_next[PW-2 -: CW]
//     - square:   phase_next[PW-1] ? all-ones : 0
//     - sawtooth: s
//     - triangle: phase_next[PW-1] ? ~t : t
//     - silence:  0
//     - enable=0: code <= 0 on the next next_sample edge; phase is frozen, not cleared.
//     - wave_sel changes are sampled only on next_sample edges; never mid-window.
//   FCW control (any cycle, independent of next_sample)
//     - FCW_MAX = 2^(PW-1)-1, the Nyquist limit.
//     - fcw_up only:   fcw <= min(fcw + FCW_STEP, FCW_MAX), saturating.
//     - fcw_down only: fcw <= (fcw < FCW_STEP) ? 0 : fcw - FCW_STEP, saturating at 0.
//     - Both fcw_up and fcw_down in the same cycle: no change.
//     - Compute with one extra bit; no wrap.
//     - Inputs are assumed already debounced and pulse-shaped upstream; a held level steps once per cycle.
// TESTING (bench params: PHASE_WIDTH=8, CODE_WIDTH=4, FCW_DEFAULT=16, FCW_STEP=16)
//   1. Reset, wave_sel=1, pulse next_sample once -> code=1 one cycle later; after 16 pulses code=0 (wrap).
//   2. wave_sel=0: pulses 1..7 -> code=0; pulse 8 (phase=128) -> code=15.
//   3. wave_sel=2: pulse 1 -> code=2; pulse 8 -> code=15; pulse 12 (phase=192) -> code=7.
//   4. fcw_up x8 -> fcw 32,48..112 then saturates at 127; fcw_down from 16 -> 0, again -> stays 0.
//   5. fcw_up and next_sample in the same cycle -> that update uses old fcw 16 (saw code=1), next uses 32.
//   6. enable=0 then next_sample -> code=0, phase held; rst mid-run -> code=0, fcw=16, phase=0 next cycle.

Source files
------------

// File: rtl/tone_nco.sv
// ---------------------------------------------------------------------------
// tone_nco
//
// Purpose:
//   Numerically controlled oscillator feeding the PWM DAC. A phase
//   accumulator advances by the frequency control word (FCW) once per DAC
//   window, on the DAC's next_sample pulse. The phase that results is mapped
//   to a square, sawtooth or triangle code. The code is registered, so the
//   DAC picks it up at the start of its next window and it stays constant for
//   that whole window.
//
// Parameters:
//   CODE_WIDTH   width of the sample code; must match the DAC code width
//   PHASE_WIDTH  phase accumulator / FCW width; must be >= CODE_WIDTH+2
//   FCW_DEFAULT  FCW loaded on reset
//   FCW_STEP     amount added/subtracted per fcw_up/fcw_down pulse
//
// Ports:
//   clk          in   system clock (single domain)
//   rst          in   synchronous active-high reset
//   next_sample  in   1-cycle pulse from the DAC: last cycle of its window
//   enable       in   1 = oscillate, 0 = freeze phase and output silence
//   wave_sel     in   0 square, 1 sawtooth, 2 triangle, 3 silence
//   fcw_up       in   1-cycle pulse: raise FCW by FCW_STEP (saturating)
//   fcw_down     in   1-cycle pulse: lower FCW by FCW_STEP (saturating at 0)
//   code         out  registered sample code to the DAC
//   fcw          out  current FCW (registered, for debug/LEDs)
// ---------------------------------------------------------------------------
module tone_nco #(
    parameter int                     CODE_WIDTH  = 10,
    parameter int                     PHASE_WIDTH = 24,
    parameter logic [PHASE_WIDTH-1:0] FCW_DEFAULT = 24'd3436,
    parameter logic [PHASE_WIDTH-1:0] FCW_STEP    = 24'd64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   next_sample,
    input  logic                   enable,
    input  logic [1:0]             wave_sel,
    input  logic                   fcw_up,
    input  logic                   fcw_down,
    output logic [CODE_WIDTH-1:0]  code,
    output logic [PHASE_WIDTH-1:0] fcw
);

    localparam logic [1:0] WAVE_SQUARE   = 2'd0;
    localparam logic [1:0] WAVE_SAWTOOTH = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;

    // Largest FCW allowed: half a cycle per sample (Nyquist). Held one bit
    // wider than the FCW so the saturation compare sees the carry.
    localparam logic [PHASE_WIDTH:0] FCW_MAX = {2'b00, {(PHASE_WIDTH-1){1'b1}}};

    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0] phase_next;
    logic [PHASE_WIDTH:0]   fcw_sum;
    logic [PHASE_WIDTH-1:0] fcw_next;
    logic [CODE_WIDTH-1:0]  saw_val;
    logic [CODE_WIDTH-1:0]  tri_val;
    logic [CODE_WIDTH-1:0]  code_next;

    // Candidate phase for the next window. The accumulator wraps silently
    // modulo 2^PHASE_WIDTH. When disabled the phase is frozen (not cleared),
    // so the tone resumes where it left off.
    always_comb begin
        phase_next = phase;
        if (enable) begin
            phase_next = phase + fcw;
        end
    end

    // Waveform mapping. The sawtooth is the top CODE_WIDTH phase bits. The
    // triangle takes the bits one position lower (double slope) and folds
    // them on the second half of the cycle, so it rises over the first half
    // and falls over the second.
    always_comb begin
        saw_val   = phase_next[PHASE_WIDTH-1 -: CODE_WIDTH];
        tri_val   = phase_next[PHASE_WIDTH-2 -: CODE_WIDTH];
        code_next = '0;
        if (enable) begin
            case (wave_sel)
                WAVE_SQUARE:   code_next = phase_next[PHASE_WIDTH-1] ? '1 : '0;
                WAVE_SAWTOOTH: code_next = saw_val;
                WAVE_TRIANGLE: code_next = phase_next[PHASE_WIDTH-1] ? ~tri_val : tri_val;
                default:       code_next = '0;
            endcase
        end
    end

    // FCW up/down control with saturation at both ends. The sum is taken one
    // bit wider so an overflow cannot wrap past the clamp. Simultaneous
    // up and down pulses cancel out.
    always_comb begin
        fcw_sum  = {1'b0, fcw} + {1'b0, FCW_STEP};
        fcw_next = fcw;
        case ({fcw_up, fcw_down})
            2'b10: begin
                if (fcw_sum > FCW_MAX) begin
                    fcw_next = FCW_MAX[PHASE_WIDTH-1:0];
                end else begin
                    fcw_next = fcw_sum[PHASE_WIDTH-1:0];
                end
            end
            2'b01: begin
                if (fcw < FCW_STEP) begin
                    fcw_next = '0;
                end else begin
                    fcw_next = fcw - FCW_STEP;
                end
            end
            default: fcw_next = fcw;
        endcase
    end

    // State registers. Phase and code only move on the DAC's next_sample
    // pulse, so wave_sel changes never show up mid-window. The phase update
    // uses the FCW registered before this edge; an FCW pulse in the same
    // cycle only affects later windows. Reset wins over everything,
    // including a coincident next_sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            fcw   <= FCW_DEFAULT;
            code  <= '0;
        end else begin
            if (next_sample) begin
                phase <= phase_next;
                code  <= code_next;
            end
            fcw <= fcw_next;
        end
    end

endmodule

// File: tb/tb_tone_nco.sv
// ---------------------------------------------------------------------------
// tb_tone_nco
//
// Directed bench for tone_nco with PHASE_WIDTH=8, CODE_WIDTH=4,
// FCW_DEFAULT=16, FCW_STEP=16. Inputs change on the falling edge, and outputs
// are compared just after the rising edge they were registered on.
// ---------------------------------------------------------------------------
module tb_tone_nco;

    logic       clk;
    logic       rst;
    logic       next_sample;
    logic       enable;
    logic [1:0] wave_sel;
    logic       fcw_up;
    logic       fcw_down;
    logic [3:0] code;
    logic [7:0] fcw;

    int checks;
    int passes;

    tone_nco #(
        .CODE_WIDTH  (4),
        .PHASE_WIDTH (8),
        .FCW_DEFAULT (8'd16),
        .FCW_STEP    (8'd16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .next_sample (next_sample),
        .enable      (enable),
        .wave_sel    (wave_sel),
        .fcw_up      (fcw_up),
        .fcw_down    (fcw_down),
        .code        (code),
        .fcw         (fcw)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of pulses starting from a falling edge. Pulses are
    // released 1 ns after the rising edge, which leaves the bench sitting
    // just after that edge, where the registered outputs can be compared.
    task automatic applyStimulus(input logic ns, input logic up, input logic down,
                                 input logic rs);
        next_sample = ns;
        fcw_up      = up;
        fcw_down    = down;
        rst         = rs;
        @(posedge clk);
        #1;
        next_sample = 1'b0;
        fcw_up      = 1'b0;
        fcw_down    = 1'b0;
        rst         = 1'b0;
    endtask

    // Return to the falling edge so the next stimulus starts there.
    task automatic realign();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        realign();
    endtask

    initial begin
        logic [7:0] up_table [8];
        checks      = 0;
        passes      = 0;
        rst         = 1'b1;
        next_sample = 1'b0;
        enable      = 1'b1;
        wave_sel    = 2'd1;
        fcw_up      = 1'b0;
        fcw_down    = 1'b0;
        up_table    = '{8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd112, 8'd127, 8'd127};

        @(negedge clk);
        doReset();
        checkOutput("reset_code", code, 0);
        checkOutput("reset_fcw", fcw, 16);

        // Sawtooth: phase steps by 16, code = phase[7:4], wraps after 16 pulses.
        $display("[TB] sawtooth");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("saw_%0d", i), code, i % 16);
            realign();
        end

        // wave_sel change without a next_sample pulse must not alter code.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        realign();
        wave_sel = 2'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wave_sel_mid_window", code, 1);
        realign();

        // Square: low for phases 16..112, all-ones from phase 128.
        $display("[TB] square");
        doReset();
        wave_sel = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("square_%0d", i), code, (i == 8) ? 15 : 0);
            realign();
        end

        // Triangle: 16 -> 2, 128 -> 15, 192 -> 7.
        $display("[TB] triangle");
        doReset();
        wave_sel = 2'd2;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 1)  checkOutput("tri_1", code, 2);
            if (i == 4)  checkOutput("tri_4", code, 8);
            if (i == 8)  checkOutput("tri_8", code, 15);
            if (i == 12) checkOutput("tri_12", code, 7);
            realign();
        end

        // Silence select forces zero.
        wave_sel = 2'd3;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("silence", code, 0);
        realign();

        // FCW up saturates at 127.
        $display("[TB] fcw control");
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("fcw_up_%0d", i + 1), fcw, up_table[i]);
            realign();
        end

        // FCW down saturates at 0.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("fcw_down_1", fcw, 0);
        realign();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("fcw_down_floor", fcw, 0);
        realign();

        // Simultaneous up and down: no change.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("fcw_both", fcw, 16);
        realign();

        // fcw_up together with next_sample: this update uses the old FCW.
        $display("[TB] fcw vs next_sample ordering");
        doReset();
        wave_sel = 2'd1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("same_cycle_code", code, 1);
        checkOutput("same_cycle_fcw", fcw, 32);
        realign();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("after_up_code", code, 3);
        realign();

        // Enable low: code silenced, phase frozen and resumed afterwards.
        $display("[TB] enable and mid-run reset");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        realign();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_disable", code, 2);
        realign();
        enable = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("disabled_code", code, 0);
        realign();
        enable = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("resume_code", code, 3);
        realign();

        // Mid-run reset with a coincident next_sample.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        realign();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("midrst_code", code, 0);
        checkOutput("midrst_fcw", fcw, 16);
        realign();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_phase", code, 1);
        realign();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
